// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM states and reply-word layout for the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    GET_COUNT,
    LOAD,
    IGNORE
  } state_e;

  // Status bit positions in tx_word, counted down from the MSB.
  localparam int ST_OVF_OFS = 0;
  localparam int ST_BAD_OFS = 1;

endpackage

// File: rtl/record_assembler.sv
// Staging shift register and word counter for one multi-word FIFO record.
module record_assembler #(
  parameter int WORD_SIZE    = 8,
  parameter int RECORD_WORDS = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              shift_en,
  input  logic [WORD_SIZE-1:0]              rx_word,
  output logic [WORD_SIZE*RECORD_WORDS-1:0] stage,
  output logic                              last
);

  localparam int TOTW = WORD_SIZE * RECORD_WORDS;
  localparam int WCW  = $clog2(RECORD_WORDS + 1);

  logic [TOTW-1:0] stage_q, stage_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;

  always_comb begin
    stage_d    = stage_q;
    word_cnt_d = word_cnt_q;
    last       = 1'b0;
    if (clear) begin
      word_cnt_d = '0;
    end else if (shift_en) begin
      // Shift in at the LSB so the first word ends up most significant.
      stage_d = (stage_q << WORD_SIZE) | TOTW'(rx_word);
      if (word_cnt_q == WCW'(RECORD_WORDS - 1)) begin
        last       = 1'b1;
        word_cnt_d = '0;
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      stage_q    <= stage_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign stage = stage_q;

endmodule

// File: rtl/spi_command_decoder.sv
// Opcode FSM between the SPI secondary word stream and the record FIFO;
// commits whole records only and drives the status reply word.
module spi_command_decoder
  import spi_cmd_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int RECORD_WORDS = 2,
  parameter int SIZE_WIDTH   = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              spi_cs,
  input  logic [WORD_SIZE-1:0]              rx_word,
  input  logic                              rx_ready,
  output logic [WORD_SIZE-1:0]              tx_word,
  input  logic [SIZE_WIDTH-1:0]             fifo_size,
  input  logic                              fifo_full,
  output logic                              fifo_wr_en,
  output logic [WORD_SIZE*RECORD_WORDS-1:0] fifo_wr_data,
  output logic                              busy,
  output logic                              overflow,
  output logic                              bad_cmd
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] rec_cnt_q, rec_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 bad_q, bad_d;
  logic                 wr_en_q, wr_en_d;
  logic [WORD_SIZE-1:0] tx_q, tx_d;
  logic [WORD_SIZE-3:0] size_ext;
  logic                 asm_clear, shift_en, last;

  record_assembler #(
    .WORD_SIZE   (WORD_SIZE),
    .RECORD_WORDS(RECORD_WORDS)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear   (asm_clear),
    .shift_en(shift_en),
    .rx_word (rx_word),
    .stage   (fifo_wr_data),
    .last    (last)
  );

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    ovf_d     = ovf_q;
    bad_d     = bad_q;
    wr_en_d   = 1'b0;
    asm_clear = 1'b0;
    shift_en  = 1'b0;
    // Chip select high aborts the frame and masks any word in flight.
    if (spi_cs) begin
      state_d   = IDLE;
      rec_cnt_d = '0;
      asm_clear = 1'b1;
    end else if (rx_ready) begin
      case (state_q)
        IDLE: begin
          if (rx_word == WORD_SIZE'(OP_NOP)) begin
            state_d = IDLE;
          end else if (rx_word == WORD_SIZE'(OP_CLEAR)) begin
            ovf_d = 1'b0;
            bad_d = 1'b0;
          end else if (rx_word == WORD_SIZE'(OP_WRITE)) begin
            state_d = GET_COUNT;
          end else begin
            bad_d   = 1'b1;
            state_d = IGNORE;
          end
        end
        GET_COUNT: begin
          rec_cnt_d = rx_word;
          asm_clear = 1'b1;
          state_d   = (rx_word == '0) ? IDLE : LOAD;
        end
        LOAD: begin
          shift_en = 1'b1;
          if (last) begin
            if (fifo_full) ovf_d = 1'b1;
            else           wr_en_d = 1'b1;
            rec_cnt_d = rec_cnt_q - WORD_SIZE'(1);
            if (rec_cnt_q == WORD_SIZE'(1)) state_d = IDLE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    size_ext                 = '0;
    size_ext[SIZE_WIDTH-1:0] = fifo_size;
    tx_d                     = '0;
    if (state_q == IDLE) begin
      tx_d[WORD_SIZE-3:0]              = size_ext;
      tx_d[WORD_SIZE-1-ST_OVF_OFS]     = ovf_q;
      tx_d[WORD_SIZE-1-ST_BAD_OFS]     = bad_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rec_cnt_q <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      tx_q      <= '0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      wr_en_q   <= wr_en_d;
      tx_q      <= tx_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign tx_word    = tx_q;
  assign busy       = (state_q != IDLE);
  assign overflow   = ovf_q;
  assign bad_cmd    = bad_q;

endmodule

// File: tb/tb_spi_command_decoder.sv
// Directed bench for spi_command_decoder at default parameters.
module tb_spi_command_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs;
  logic [7:0]  rx_word;
  logic        rx_ready;
  logic [7:0]  tx_word;
  logic [4:0]  fifo_size;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        busy, overflow, bad_cmd;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [15:0] wr_last = '0;

  spi_command_decoder dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .rx_word(rx_word), .rx_ready(rx_ready),
    .tx_word(tx_word), .fifo_size(fifo_size), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .busy(busy),
    .overflow(overflow), .bad_cmd(bad_cmd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_last <= fifo_wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w);
    rx_word  = w;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic        cs;
    logic        rdy;
    logic [7:0]  word;
    logic        full;
    logic [4:0]  size;
    logic        wr;
    logic [15:0] data;
    logic        busy;
    logic [7:0]  tx;
    logic        ovf;
    logic        bad;
  } vec_t;

  vec_t vecs[17];
  int   wr0;

  initial begin
    // Outputs after each edge; tx_word lags the registered state by one edge.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 16'h0000, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b0, 5'd3, 1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h02, 1'b0, 5'd3, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 5'd3, 1'b0, 16'h00AA, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hBB, 1'b0, 5'd3, 1'b1, 16'hAABB, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'hCC, 1'b0, 5'd3, 1'b0, 16'hBBCC, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'hDD, 1'b0, 5'd3, 1'b1, 16'hCCDD, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 16'hCCDD, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 16'hCCDD, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h02, 1'b0, 5'd3, 1'b0, 16'hCCDD, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h01, 1'b0, 5'd3, 1'b0, 16'hCCDD, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h11, 1'b0, 5'd3, 1'b0, 16'hDD11, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h22, 1'b1, 5'd3, 1'b0, 16'h1122, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 16'h1122, 1'b0, 8'h83, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 8'h01, 1'b0, 5'd3, 1'b0, 16'h1122, 1'b0, 8'h83, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 16'h1122, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 16'h1122, 1'b0, 8'h03, 1'b0, 1'b0};

    rst = 1'b1; spi_cs = 1'b1; rx_word = '0; rx_ready = 1'b0;
    fifo_size = 5'd3; fifo_full = 1'b0;
    #1;
    check("reset tx_word", tx_word, 8'h00);
    check("reset wr_en", fifo_wr_en, 1'b0);
    check("reset wr_data", fifo_wr_data, 16'h0000);
    check("reset busy", busy, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset bad_cmd", bad_cmd, 1'b0);
    tick();
    rst = 1'b0;

    // Two-record write, then overflow drop and CLEAR.
    for (int i = 0; i < 17; i++) begin
      spi_cs    = vecs[i].cs;
      rx_ready  = vecs[i].rdy;
      rx_word   = vecs[i].word;
      fifo_full = vecs[i].full;
      fifo_size = vecs[i].size;
      tick();
      check($sformatf("vec%0d wr_en", i),   fifo_wr_en,   vecs[i].wr);
      check($sformatf("vec%0d wr_data", i), fifo_wr_data, vecs[i].data);
      check($sformatf("vec%0d busy", i),    busy,         vecs[i].busy);
      check($sformatf("vec%0d tx_word", i), tx_word,      vecs[i].tx);
      check($sformatf("vec%0d overflow", i), overflow,    vecs[i].ovf);
      check($sformatf("vec%0d bad_cmd", i), bad_cmd,      vecs[i].bad);
    end
    rx_ready = 1'b0; fifo_full = 1'b0;
    tick();
    check("table write count", wr_cnt, 2);

    // Abort mid-record; the word coinciding with spi_cs high is dropped.
    wr0 = wr_cnt;
    spi_cs = 1'b0;
    send(8'h02); send(8'h03); send(8'h11);
    check("abort busy before cs", busy, 1'b1);
    spi_cs = 1'b1;
    send(8'h99);
    check("abort busy", busy, 1'b0);
    check("abort wr_en", fifo_wr_en, 1'b0);
    tick();
    check("abort no write", wr_cnt, wr0);
    check("abort tx_word", tx_word, 8'h03);
    spi_cs = 1'b0;
    send(8'h02); send(8'h01); send(8'h33); send(8'h44);
    tick();
    check("after abort write count", wr_cnt, wr0 + 1);
    check("after abort data", wr_last, 16'h3344);
    check("after abort busy", busy, 1'b0);
    spi_cs = 1'b1;
    tick();

    // Unknown opcode ignores the rest of the frame.
    wr0 = wr_cnt;
    spi_cs = 1'b0;
    send(8'h7F);
    check("badcmd flag", bad_cmd, 1'b1);
    check("badcmd busy", busy, 1'b1);
    send(8'h02); send(8'h01); send(8'h55); send(8'h66);
    tick();
    check("badcmd no write", wr_cnt, wr0);
    check("ignore busy", busy, 1'b1);
    spi_cs = 1'b1;
    tick();
    check("ignore exit busy", busy, 1'b0);
    check("badcmd sticky", bad_cmd, 1'b1);
    tick();
    check("badcmd tx_word", tx_word, 8'h43);
    spi_cs = 1'b0;
    send(8'h02); send(8'h01); send(8'h55); send(8'h66);
    tick();
    check("new frame write count", wr_cnt, wr0 + 1);
    check("new frame data", wr_last, 16'h5566);
    send(8'h01);
    check("clear bad_cmd", bad_cmd, 1'b0);

    // Zero record count returns straight to IDLE.
    wr0 = wr_cnt;
    fifo_size = 5'd5;
    send(8'h02); send(8'h00);
    check("count0 busy", busy, 1'b0);
    send(8'h00);
    check("nop busy", busy, 1'b0);
    check("nop bad_cmd", bad_cmd, 1'b0);
    tick(); tick();
    check("count0 tx_word", tx_word, 8'h05);
    check("count0 no write", wr_cnt, wr0);

    // Asynchronous reset in the middle of a record.
    send(8'h02); send(8'h01); send(8'hAB);
    check("preload busy", busy, 1'b1);
    check("preload data", fifo_wr_data, 16'h66AB);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", busy, 1'b0);
    check("async rst data", fifo_wr_data, 16'h0000);
    check("async rst wr_en", fifo_wr_en, 1'b0);
    check("async rst tx_word", tx_word, 8'h00);
    check("async rst overflow", overflow, 1'b0);
    check("async rst bad_cmd", bad_cmd, 1'b0);
    tick();
    rst = 1'b0;
    send(8'h00);
    tick();
    check("post rst no write", wr_cnt, wr0);
    check("post rst busy", busy, 1'b0);
    check("post rst tx_word", tx_word, 8'h05);
    spi_cs = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
